// File: rtl/hazard_pkg.sv
// Shared optype/forwarding codes and small helpers for the hazard detection unit.
package hazard_pkg;

   localparam int unsigned OPT_W = 2;
   localparam int unsigned FWD_W = 2;

   // Instruction class carried down the shadow pipeline
   typedef enum logic [OPT_W-1:0] {
      OPT_NONE  = 2'b00,
      OPT_ALU   = 2'b01,
      OPT_LOAD  = 2'b10,
      OPT_STORE = 2'b11
   } optype_e;

   // Operand source select driven to the ID-stage muxes
   typedef enum logic [FWD_W-1:0] {
      FWD_RF    = 2'b00,
      FWD_EX    = 2'b01,
      FWD_MEM   = 2'b10,
      FWD_MEMLD = 2'b11
   } fwd_e;

   // An entry produces a register result only for ALU/LOAD with a non-x0 target
   function automatic logic writes_rd(input optype_e op, input logic rd_nz);
      return rd_nz && ((op == OPT_ALU) || (op == OPT_LOAD));
   endfunction

   // MEM-stage source: load data for loads, ALU result otherwise
   function automatic fwd_e mem_fwd_code(input optype_e op);
      return (op == OPT_LOAD) ? FWD_MEMLD : FWD_MEM;
   endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow copy of the EX/MEM/WB stages: {optype, rd, rs2} with bubble insert.
// rs2 is only consumed from MEM (store-data forwarding), so WB keeps optype/rd only.
module hazard_shadow_pipe
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_bubble,
   input  optype_e           i_id_op,
   input  logic [REG_AW-1:0] i_id_rd,
   input  logic [REG_AW-1:0] i_id_rs2,
   output optype_e           o_ex_op,
   output logic [REG_AW-1:0] o_ex_rd,
   output optype_e           o_mem_op,
   output logic [REG_AW-1:0] o_mem_rd,
   output logic [REG_AW-1:0] o_mem_rs2,
   output optype_e           o_wb_op,
   output logic [REG_AW-1:0] o_wb_rd
);

   optype_e           r_ex_op,  r_mem_op, r_wb_op;
   logic [REG_AW-1:0] r_ex_rd,  r_mem_rd, r_wb_rd;
   logic [REG_AW-1:0] r_ex_rs2, r_mem_rs2;

   // Advance every cycle; EX takes a bubble when ID is squashed or invalid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_op   <= OPT_NONE;
         r_ex_rd   <= '0;
         r_ex_rs2  <= '0;
         r_mem_op  <= OPT_NONE;
         r_mem_rd  <= '0;
         r_mem_rs2 <= '0;
         r_wb_op   <= OPT_NONE;
         r_wb_rd   <= '0;
      end else begin
         r_wb_op   <= r_mem_op;
         r_wb_rd   <= r_mem_rd;
         r_mem_op  <= r_ex_op;
         r_mem_rd  <= r_ex_rd;
         r_mem_rs2 <= r_ex_rs2;
         if (i_bubble) begin
            r_ex_op  <= OPT_NONE;
            r_ex_rd  <= '0;
            r_ex_rs2 <= '0;
         end else begin
            r_ex_op  <= i_id_op;
            r_ex_rd  <= i_id_rd;
            r_ex_rs2 <= i_id_rs2;
         end
      end
   end

   assign o_ex_op   = r_ex_op;
   assign o_ex_rd   = r_ex_rd;
   assign o_mem_op  = r_mem_op;
   assign o_mem_rd  = r_mem_rd;
   assign o_mem_rs2 = r_mem_rs2;
   assign o_wb_op   = r_wb_op;
   assign o_wb_rd   = r_wb_rd;

endmodule

// File: rtl/hazard_detect_unit.sv
// Hazard detection for the 5-stage RV32I core: forwarding selects, store-data
// forwarding, load-use stall and taken-branch flush, all zero-latency from ID.
// Optional cycle counters for stalls/flushes when HAZARD_PERF_EN is defined.
module hazard_detect_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW = 5
`ifdef HAZARD_PERF_EN
   ,
   parameter int unsigned CNT_W  = 32
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] rs1_id,
   input  logic [REG_AW-1:0] rs2_id,
   input  logic [REG_AW-1:0] rd_id,
   input  logic              rs1use_id,
   input  logic              rs2use_id,
   input  logic [1:0]        optype_id,
   input  logic              branch_id,
   output logic              pc_en_if,
   output logic              reg_fd_stall,
   output logic              reg_fd_flush,
   output logic              reg_de_flush,
   output logic [1:0]        fwd_a_ctrl,
   output logic [1:0]        fwd_b_ctrl,
   output logic              fwd_ls_ctrl
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   // An invalid ID slot behaves as a NONE instruction that reads nothing
   logic    w_rs1use, w_rs2use, w_branch;
   optype_e w_id_op;

   assign w_rs1use = id_valid & rs1use_id;
   assign w_rs2use = id_valid & rs2use_id;
   assign w_branch = id_valid & branch_id;
   assign w_id_op  = id_valid ? optype_e'(optype_id) : OPT_NONE;

   optype_e           w_ex_op, w_mem_op, w_wb_op;
   logic [REG_AW-1:0] w_ex_rd, w_mem_rd, w_mem_rs2, w_wb_rd;
   logic              w_bubble;

   hazard_shadow_pipe #(
      .REG_AW (REG_AW)
   ) u_shadow (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_bubble  (w_bubble),
      .i_id_op   (w_id_op),
      .i_id_rd   (rd_id),
      .i_id_rs2  (rs2_id),
      .o_ex_op   (w_ex_op),
      .o_ex_rd   (w_ex_rd),
      .o_mem_op  (w_mem_op),
      .o_mem_rd  (w_mem_rd),
      .o_mem_rs2 (w_mem_rs2),
      .o_wb_op   (w_wb_op),
      .o_wb_rd   (w_wb_rd)
   );

   logic w_ex_wr, w_mem_wr;

   assign w_ex_wr  = writes_rd(w_ex_op,  |w_ex_rd);
   assign w_mem_wr = writes_rd(w_mem_op, |w_mem_rd);

   // Operand forwarding; EX result is younger and wins over MEM
   fwd_e w_fwd_a, w_fwd_b;

   always_comb begin
      w_fwd_a = FWD_RF;
      w_fwd_b = FWD_RF;
      if (w_rs1use) begin
         if (w_ex_wr && (w_ex_op == OPT_ALU) && (w_ex_rd == rs1_id)) begin
            w_fwd_a = FWD_EX;
         end else if (w_mem_wr && (w_mem_rd == rs1_id)) begin
            w_fwd_a = mem_fwd_code(w_mem_op);
         end
      end
      if (w_rs2use) begin
         if (w_ex_wr && (w_ex_op == OPT_ALU) && (w_ex_rd == rs2_id)) begin
            w_fwd_b = FWD_EX;
         end else if (w_mem_wr && (w_mem_rd == rs2_id)) begin
            w_fwd_b = mem_fwd_code(w_mem_op);
         end
      end
   end

   // Load-use: a store's rs2 is exempt because it is patched later from WB
   logic w_ex_is_ld, w_ld_use_a, w_ld_use_b, w_stall;

   assign w_ex_is_ld = (w_ex_op == OPT_LOAD) && (w_ex_rd != '0);
   assign w_ld_use_a = w_rs1use && (w_ex_rd == rs1_id);
   assign w_ld_use_b = w_rs2use && (w_ex_rd == rs2_id) && (w_id_op != OPT_STORE);
   assign w_stall    = w_ex_is_ld && (w_ld_use_a || w_ld_use_b);
   assign w_bubble   = w_stall | ~id_valid;

   // Store in MEM whose data register is being written by a load now in WB
   logic w_ls_fwd;

   assign w_ls_fwd = (w_mem_op == OPT_STORE) && (w_wb_op == OPT_LOAD) &&
                     (w_wb_rd != '0) && (w_wb_rd == w_mem_rs2);

   // Branch flush yields to a stall so the branch is re-evaluated next cycle
   logic w_flush;

   assign w_flush = w_branch & ~w_stall;

   // Outputs held at their idle values while reset is asserted
   assign pc_en_if     = ~rst_n | ~w_stall;
   assign reg_fd_stall =  rst_n &  w_stall;
   assign reg_de_flush =  rst_n &  w_stall;
   assign reg_fd_flush =  rst_n &  w_flush;
   assign fwd_a_ctrl   =  rst_n ? 2'(w_fwd_a) : 2'(FWD_RF);
   assign fwd_b_ctrl   =  rst_n ? 2'(w_fwd_b) : 2'(FWD_RF);
   assign fwd_ls_ctrl  =  rst_n &  w_ls_fwd;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   // Saturating counts of stall cycles and flush cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (w_flush && !(&r_flush_cnt)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Self-checking bench for hazard_detect_unit (HAZARD_PERF_EN optional).
module tb_hazard_detect_unit;

   localparam logic [1:0] NONE  = 2'b00;
   localparam logic [1:0] ALU   = 2'b01;
   localparam logic [1:0] LOAD  = 2'b10;
   localparam logic [1:0] STORE = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid, rs1use_id, rs2use_id, branch_id;
   logic [4:0] rs1_id, rs2_id, rd_id;
   logic [1:0] optype_id;
   logic       pc_en_if, reg_fd_stall, reg_fd_flush, reg_de_flush, fwd_ls_ctrl;
   logic [1:0] fwd_a_ctrl, fwd_b_ctrl;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   always #5 clk = ~clk;

   hazard_detect_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .rs1_id       (rs1_id),
      .rs2_id       (rs2_id),
      .rd_id        (rd_id),
      .rs1use_id    (rs1use_id),
      .rs2use_id    (rs2use_id),
      .optype_id    (optype_id),
      .branch_id    (branch_id),
      .pc_en_if     (pc_en_if),
      .reg_fd_stall (reg_fd_stall),
      .reg_fd_flush (reg_fd_flush),
      .reg_de_flush (reg_de_flush),
      .fwd_a_ctrl   (fwd_a_ctrl),
      .fwd_b_ctrl   (fwd_b_ctrl),
      .fwd_ls_ctrl  (fwd_ls_ctrl)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: history of instructions that left ID, most recent first (EX, MEM, WB)
   typedef struct {
      logic [1:0] op;
      logic [4:0] rd;
      logic [4:0] rs2;
   } rec_t;

   rec_t hist[$];

   function automatic bit produces(input rec_t r);
      return ((r.op == ALU) || (r.op == LOAD)) && (r.rd != 5'd0);
   endfunction

   function automatic logic [1:0] src_for(input logic [4:0] r);
      if (produces(hist[0]) && hist[0].op == ALU && hist[0].rd == r) return 2'b01;
      if (produces(hist[1]) && hist[1].rd == r) return (hist[1].op == LOAD) ? 2'b11 : 2'b10;
      return 2'b00;
   endfunction

   task automatic model_out(output logic pc_en, output logic fds, output logic fdf,
                            output logic def, output logic [1:0] fa, output logic [1:0] fb,
                            output logic ls);
      bit u1, u2, br, st;
      logic [1:0] op;
      pc_en = 1'b1; fds = 1'b0; fdf = 1'b0; def = 1'b0; fa = 2'b00; fb = 2'b00; ls = 1'b0;
      if (rst_n) begin
         u1 = id_valid && rs1use_id;
         u2 = id_valid && rs2use_id;
         br = id_valid && branch_id;
         op = id_valid ? optype_id : NONE;
         st = (hist[0].op == LOAD) && (hist[0].rd != 5'd0) &&
              ((u1 && hist[0].rd == rs1_id) || (u2 && hist[0].rd == rs2_id && op != STORE));
         pc_en = !st;
         fds   = st;
         def   = st;
         fdf   = br && !st;
         fa    = u1 ? src_for(rs1_id) : 2'b00;
         fb    = u2 ? src_for(rs2_id) : 2'b00;
         ls    = (hist[1].op == STORE) && (hist[2].op == LOAD) &&
                 (hist[2].rd != 5'd0) && (hist[2].rd == hist[1].rs2);
      end
   endtask

   task automatic fill_bubbles();
      rec_t b;
      b.op = NONE; b.rd = 5'd0; b.rs2 = 5'd0;
      hist.delete();
      repeat (3) hist.push_back(b);
   endtask

   // Model advance: the ID instruction (or a bubble) enters history each edge
   always @(posedge clk or negedge rst_n) begin
      logic pe, fds, fdf, def, ls;
      logic [1:0] fa, fb;
      rec_t r;
      if (!rst_n) begin
         fill_bubbles();
      end else begin
         model_out(pe, fds, fdf, def, fa, fb, ls);
         if (fds || !id_valid) begin
            r.op = NONE; r.rd = 5'd0; r.rs2 = 5'd0;
         end else begin
            r.op = optype_id; r.rd = rd_id; r.rs2 = rs2_id;
         end
         hist.push_front(r);
         void'(hist.pop_back());
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      logic pe, fds, fdf, def, ls;
      logic [1:0] fa, fb;
      if (chk_en) begin
         model_out(pe, fds, fdf, def, fa, fb, ls);
         chk("m_pc_en_if",     32'(pc_en_if),     32'(pe));
         chk("m_reg_fd_stall", 32'(reg_fd_stall), 32'(fds));
         chk("m_reg_fd_flush", 32'(reg_fd_flush), 32'(fdf));
         chk("m_reg_de_flush", 32'(reg_de_flush), 32'(def));
         chk("m_fwd_a_ctrl",   32'(fwd_a_ctrl),   32'(fa));
         chk("m_fwd_b_ctrl",   32'(fwd_b_ctrl),   32'(fb));
         chk("m_fwd_ls_ctrl",  32'(fwd_ls_ctrl),  32'(ls));
      end
   end

   task automatic issue(input logic v, input logic [1:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic br);
      id_valid = v; optype_id = op; rd_id = rd; rs1_id = rs1; rs2_id = rs2;
      rs1use_id = u1; rs2use_id = u2; branch_id = br;
   endtask

   task automatic nop();
      issue(1'b0, NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      repeat (3) begin
         nop();
         tick();
      end
   endtask

   initial begin
      fill_bubbles();
      // Reset forces idle outputs even with a branch in ID
      issue(1'b1, ALU, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);
      chk_en = 1'b1;
      #2;
      chk("rst_pc_en",    32'(pc_en_if),     32'd1);
      chk("rst_flush",    32'(reg_fd_flush), 32'd0);
      chk("rst_stall",    32'(reg_fd_stall), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      drain();

      // 1) add x1; add x2,x1,x3
      issue(1'b1, ALU, 5'd1, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0);
      tick();
      issue(1'b1, ALU, 5'd2, 5'd1, 5'd3, 1'b1, 1'b1, 1'b0);
      #2;
      chk("t1_fwd_a", 32'(fwd_a_ctrl),   32'd1);
      chk("t1_stall", 32'(reg_fd_stall), 32'd0);
      tick();
      drain();

      // 2) add x1; nop; sub x2,x1,x1
      issue(1'b1, ALU, 5'd1, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0);
      tick();
      nop();
      tick();
      issue(1'b1, ALU, 5'd2, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0);
      #2;
      chk("t2_fwd_a", 32'(fwd_a_ctrl), 32'd2);
      chk("t2_fwd_b", 32'(fwd_b_ctrl), 32'd2);
      tick();
      drain();

      // 3) lw x1; add x2,x3,x1 -> one stall cycle, then load-data forward
      issue(1'b1, LOAD, 5'd1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
      issue(1'b1, ALU, 5'd2, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0);
      #2;
      chk("t3_pc_en",    32'(pc_en_if),     32'd0);
      chk("t3_stall",    32'(reg_fd_stall), 32'd1);
      chk("t3_de_flush", 32'(reg_de_flush), 32'd1);
      tick();
      #2;
      chk("t3_fwd_b",    32'(fwd_b_ctrl),   32'd3);
      chk("t3_nostall",  32'(reg_fd_stall), 32'd0);
      tick();
      drain();

      // 4) lw x5; sw x5,0(x6) -> no stall, WB->MEM store data when sw in MEM
      issue(1'b1, LOAD, 5'd5, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
      issue(1'b1, STORE, 5'd0, 5'd6, 5'd5, 1'b1, 1'b1, 1'b0);
      #2;
      chk("t4_stall", 32'(reg_fd_stall), 32'd0);
      chk("t4_ls_id", 32'(fwd_ls_ctrl),  32'd0);
      tick();
      nop();
      #2;
      chk("t4_ls_ex", 32'(fwd_ls_ctrl), 32'd0);
      tick();
      #2;
      chk("t4_ls_mem", 32'(fwd_ls_ctrl), 32'd1);
      tick();
      #2;
      chk("t4_ls_wb", 32'(fwd_ls_ctrl), 32'd0);
      drain();

      // 5) x0 never forwards; branch flush; branch vs load-use
      issue(1'b1, ALU, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
      issue(1'b1, ALU, 5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
      #2;
      chk("t5_fwd_a", 32'(fwd_a_ctrl),   32'd0);
      chk("t5_fwd_b", 32'(fwd_b_ctrl),   32'd0);
      chk("t5_flush", 32'(reg_fd_flush), 32'd1);
      tick();
      drain();
      issue(1'b1, LOAD, 5'd7, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
      issue(1'b1, NONE, 5'd0, 5'd7, 5'd8, 1'b1, 1'b1, 1'b1);
      #2;
      chk("t5_br_stall",   32'(reg_fd_stall), 32'd1);
      chk("t5_br_noflush", 32'(reg_fd_flush), 32'd0);
      tick();
      #2;
      chk("t5_br_flush",   32'(reg_fd_flush), 32'd1);
      chk("t5_br_fwd_a",   32'(fwd_a_ctrl),   32'd3);
      tick();
      drain();
`ifdef HAZARD_PERF_EN
      chk("cnt_stall", stall_cnt, 32'd2);
      chk("cnt_flush", flush_cnt, 32'd2);
`endif

      // 6) reset mid-stream clears the shadow load
      issue(1'b1, LOAD, 5'd1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
      issue(1'b1, ALU, 5'd2, 5'd1, 5'd3, 1'b1, 1'b1, 1'b0);
      #2;
      chk("t6_pre_stall", 32'(reg_fd_stall), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_pc_en", 32'(pc_en_if),     32'd1);
      chk("t6_rst_stall", 32'(reg_fd_stall), 32'd0);
      tick();
      rst_n = 1'b1;
      #2;
      chk("t6_stall", 32'(reg_fd_stall), 32'd0);
      chk("t6_fwd_a", 32'(fwd_a_ctrl),   32'd0);
`ifdef HAZARD_PERF_EN
      chk("t6_cnt_stall", stall_cnt, 32'd0);
      chk("t6_cnt_flush", flush_cnt, 32'd0);
`endif
      tick();
      drain();

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
